// File: rtl/product_display_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | product_display_pkg: shared types/constants for BCD product view |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package product_display_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  localparam logic [1:0] SLOT_HUND  = 2'd0;
  localparam logic [1:0] SLOT_TENS  = 2'd1;
  localparam logic [1:0] SLOT_UNITS = 2'd2;
  localparam logic [1:0] SLOT_BLANK = 2'd3;

  // Segment patterns, bit order gfedcba, active-high
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bcd_to_seg7: BCD digit to 7-segment decoder with blank override  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module bcd_to_seg7
  import product_display_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b0000000;
    if (!blank_i) begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = 7'b0000000;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/product_bcd_display.sv
`default_nettype none
// +------------------------------------------------------------------+
// | product_bcd_display: sequential double-dabble + muxed 7-seg scan |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module product_bcd_display
  import product_display_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int DWELL  = 4_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [1:0]            digit_sel
);

  localparam int ITER_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int BCD_W   = 4 * DIGITS;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     shift_q;
  logic [BCD_W-1:0]     work_q;
  logic [ITER_W-1:0]    iter_q;
  logic [BCD_W-1:0]     bcd_q;
  logic                 done_q;
  logic                 valid_q;
  logic [DWELL_W-1:0]   dwell_q;
  logic [1:0]           sel_q;
  logic [6:0]           seg_q;

  logic [BCD_W-1:0]     w_adj;
  logic [BCD_W-1:0]     w_shifted;
  logic                 w_last;
  logic [3:0]           w_hund, w_tens, w_units;
  logic [3:0]           w_digit;
  logic                 w_blank;
  logic [6:0]           w_seg;

  assign w_last = (state_q == CONVERT) && (iter_q == ITER_W'(WIDTH - 1));

  // Add-3 correction on every nibble >= 5 precedes each shift
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign w_adj[4*g +: 4] = (work_q[4*g +: 4] >= 4'd5) ? work_q[4*g +: 4] + 4'd3
                                                        : work_q[4*g +: 4];
  end

  assign w_shifted = (w_adj << 1) | {{(BCD_W-1){1'b0}}, shift_q[WIDTH-1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)  state_d = CONVERT;
      CONVERT: if (w_last) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CONVERT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      work_q  <= '0;
      iter_q  <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE && start) begin
        shift_q <= value;
        work_q  <= '0;
        iter_q  <= '0;
      end else if (state_q == CONVERT) begin
        work_q  <= w_shifted;
        shift_q <= shift_q << 1;
        iter_q  <= iter_q + ITER_W'(1);
        if (w_last) begin
          bcd_q   <= w_shifted;
          done_q  <= 1'b1;
          valid_q <= 1'b1;
        end
      end
    end
  end

  // Scanner restarts at the hundreds slot whenever a fresh result lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q <= '0;
      sel_q   <= SLOT_HUND;
      seg_q   <= 7'b0000000;
    end else begin
      seg_q <= w_seg;
      if (w_last) begin
        dwell_q <= '0;
        sel_q   <= SLOT_HUND;
      end else if (dwell_q == DWELL_W'(DWELL - 1)) begin
        dwell_q <= '0;
        sel_q   <= sel_q + 2'd1;
      end else begin
        dwell_q <= dwell_q + DWELL_W'(1);
      end
    end
  end

  assign w_hund  = bcd_q[BCD_W-1 -: 4];
  assign w_tens  = bcd_q[BCD_W-5 -: 4];
  assign w_units = bcd_q[3:0];

  always_comb begin
    w_digit = w_units;
    w_blank = !valid_q;
    case (sel_q)
      SLOT_HUND: begin
        w_digit = w_hund;
        w_blank = w_blank || (w_hund == 4'd0);
      end
      SLOT_TENS: begin
        w_digit = w_tens;
        w_blank = w_blank || (w_hund == 4'd0 && w_tens == 4'd0);
      end
      SLOT_UNITS: w_digit = w_units;
      default:    w_blank = 1'b1;
    endcase
  end

  bcd_to_seg7 u_seg7 (
    .digit_i (w_digit),
    .blank_i (w_blank),
    .seg_o   (w_seg)
  );

  assign done      = done_q;
  assign bcd       = bcd_q;
  assign seg       = seg_q;
  assign dp        = 1'b0;
  assign digit_sel = sel_q;

endmodule
`default_nettype wire

// File: doc/product_bcd_display.md
Name: product_bcd_display

Overview:
- Downstream consumer of the 4x4 multiplier's registered 8-bit product.
- Converts the product to three BCD digits with a sequential double-dabble (one shift per clock).
- Scans the digits onto the single 7-segment display (uo_out) in a time-multiplexed sequence: hundreds, tens, units, blank gap.
- Sits in the same top-level wrapper; uo_out is unused there today.

Parameters:
- WIDTH, 8, binary input width; the iteration count equals WIDTH.
- DIGITS, 3, BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH-1.
- DWELL, 4_000_000, clock cycles each display slot is held. Benches override it to 4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to convert value.
- value  input  WIDTH  binary product to convert; sampled only on the accepted start cycle.
- busy  output  1  high while conversion iterations run.
- done  output  1  one-cycle pulse when bcd is updated.
- bcd  output  4*DIGITS  packed result, hundreds in the top nibble.
- seg  output  7  segments a..g on seg[0]..seg[6], active-high.
- dp  output  1  decimal point, always 0.
- digit_sel  output  2  current slot: 0=hundreds, 1=tens, 2=units, 3=blank.

Behaviour:

Reset (asynchronous, immediate):
- State goes to IDLE; busy=0, done=0, bcd=0, seg=0, digit_sel=0.
- Dwell counter=0; the valid flag (meaning "a result has been displayed") is cleared.
- Reset mid-conversion discards the partial result.

FSM states: IDLE, CONVERT.
- IDLE: start=1 at a rising edge latches value into the shift register, clears the BCD work register and the iteration counter, and moves to CONVERT.
- CONVERT: each edge first adds 3 to every work nibble >= 5, then shifts {work, shift} left by 1.
- After the WIDTH-th shift, the edge loads bcd, pulses done for one cycle, sets valid, and returns to IDLE.

Latency:
- If start is sampled at edge k, busy is high for cycles k+1..k+WIDTH (8 cycles).
- bcd and done change at edge k+WIDTH.
- Back-to-back operation is allowed: start may be high in the cycle done is high, and is accepted from IDLE.

Boundary rules:
- start is ignored while in CONVERT; no queueing.
- value changes outside the accepted start cycle have no effect.
- For all inputs 0..2^WIDTH-1, bcd must equal the decimal value; e.g. 255 gives 0x255.

Display scanner (independent of the FSM):
- Always runs and reads only the bcd register, so the old result keeps displaying during CONVERT.
- The dwell counter counts 0..DWELL-1. On wrap, digit_sel advances 0->1->2->3->0.
- digit_sel is reset to 0 at the edge where done pulses, and the dwell counter is cleared at that edge.
- seg is registered: it reflects digit_sel and bcd with one cycle of latency relative to their update.

Blanking (seg=0):
- When valid=0.
- When digit_sel=3.
- For hundreds, when the hundreds digit is 0.
- For tens, when both hundreds and tens are 0.
- Units are always shown, so 0 displays as a single "0".

Segment patterns (gfedcba, active-high):
- 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110.
- 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
- Nibbles >9 are unreachable; output 0 for them.

Decomposition:
- Package product_display_pkg holds:
  - the state enum (IDLE, CONVERT);
  - slot constants SLOT_HUND=0, SLOT_TENS=1, SLOT_UNITS=2, SLOT_BLANK=3;
  - the ten 7-bit segment constants.
- One combinational sub-module, bcd_to_seg7 (4-bit digit plus blank input -> 7-bit seg), instantiated once on the selected digit.

Test Plan:
- Reset held, then released with no start -> busy=0, done=0, bcd=0x000, seg=0 for all slots; digit_sel cycles 0,1,2,3 every 4 cycles (DWELL=4).
- start with value=225 (15x15) at edge k -> busy high exactly 8 cycles; done single pulse at edge k+8; bcd=0x225; slots show 1011011, 1011011, 1101101, 0000000.
- value=7 -> bcd=0x007; hundreds and tens slots blank, units=0000111. Then value=0 -> units=0111111, others blank.
- start asserted again at cycles k+3 and k+5 during a conversion of 42 -> ignored; single done; bcd=0x042. Then start asserted during the done cycle with value=99 -> accepted; bcd=0x099 eight cycles later.
- Exhaustive sweep of value 0..255 -> bcd matches the decimal reference for every value.
- rst pulsed asynchronously at cycle k+4 of a conversion -> outputs clear immediately, no done pulse, valid=0, display blank until the next completed conversion.
